// File: rtl/sakebi_fifo_pkg.sv
// Shared helpers for the sakebi dual-clock FIFO: Gray/binary conversion and pointer sizing.
// The conversion helpers operate on a 32-bit container, so they cover any pointer width up to 32.
package sakebi_fifo_pkg;

  localparam int MAX_PTR_W = 32;

  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
    logic [MAX_PTR_W-1:0] b;
    b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // One extra bit beyond the RAM address distinguishes full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sakebi_gray_sync.sv
// Two-flop synchroniser for a Gray-coded pointer, converted back to binary in the
// destination domain.
module sakebi_gray_sync
  import sakebi_fifo_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= i_gray;
      sync_p1 <= sync_p0;
    end
  end

  assign o_bin = WIDTH'(gray2bin(MAX_PTR_W'(sync_p1)));

endmodule

// File: rtl/sakebi_async_fifo_lvl.sv
// Dual-clock FIFO with per-domain fill levels, almost-full/empty flags and an FWFT read port.
// Define SAKEBI_FIFO_ERR_FLAGS_EN to add sticky o_wr_overflow / o_rd_underflow outputs.
module sakebi_async_fifo_lvl
  import sakebi_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH    = 8,
  parameter  int DEPTH         = 16,
  parameter  int AFULL_THRESH  = DEPTH - 2,
  parameter  int AEMPTY_THRESH = 2,
  localparam int ADDR_WIDTH    = $clog2(DEPTH),
  localparam int PTR_W         = ptr_width(DEPTH)
) (
  input  logic                  i_wr_clk,
  input  logic                  i_wr_rstn,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_ready,
  output logic [ADDR_WIDTH:0]   o_wr_level,
  output logic                  o_wr_almost_full,
  input  logic                  i_rd_clk,
  input  logic                  i_rd_rstn,
  input  logic                  i_rd_en,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [ADDR_WIDTH:0]   o_rd_level,
  output logic                  o_rd_almost_empty
`ifdef SAKEBI_FIFO_ERR_FLAGS_EN
  ,
  output logic                  o_wr_overflow,
  output logic                  o_rd_underflow
`endif
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_bin, wr_bin_nxt, wr_gray, rd_pop_sync_bin, wr_level;
  logic             wr_full, wr_push;

  logic [PTR_W-1:0] rd_bin, rd_pop_bin, rd_pop_bin_nxt, rd_pop_gray, wr_sync_bin, rd_ram_cnt;
  logic             rd_empty, rd_load, rd_pop;

  // ---- write domain ----
  // Level difference equals DEPTH exactly when the Gray pointers differ only in their top two bits.
  assign wr_level   = wr_bin - rd_pop_sync_bin;
  assign wr_full    = (wr_level == PTR_W'(DEPTH));
  assign wr_push    = i_wr_en && !wr_full;
  assign wr_bin_nxt = wr_bin + 1'b1;

  always_ff @(posedge i_wr_clk or negedge i_wr_rstn) begin
    if (!i_wr_rstn) begin
      wr_bin  <= '0;
      wr_gray <= '0;
    end else if (wr_push) begin
      wr_bin  <= wr_bin_nxt;
      wr_gray <= PTR_W'(bin2gray(MAX_PTR_W'(wr_bin_nxt)));
    end
  end

  always_ff @(posedge i_wr_clk) begin
    if (wr_push) mem[wr_bin[ADDR_WIDTH-1:0]] <= i_wr_data;
  end

  assign o_wr_ready       = !wr_full;
  assign o_wr_level       = wr_level;
  assign o_wr_almost_full = (wr_level >= PTR_W'(AFULL_THRESH));

  sakebi_gray_sync #(.WIDTH(PTR_W)) u_rd2wr_sync (
    .i_clk  (i_wr_clk),
    .i_rstn (i_wr_rstn),
    .i_gray (rd_pop_gray),
    .o_bin  (rd_pop_sync_bin)
  );

  // ---- read domain ----
  // rd_bin tracks words fetched into the output register; rd_pop_bin tracks words handed
  // to the consumer. Only the latter frees space, so the held output word keeps its RAM slot.
  assign rd_ram_cnt     = wr_sync_bin - rd_bin;
  assign rd_empty       = (rd_ram_cnt == '0);
  assign rd_load        = !rd_empty && (!o_rd_valid || i_rd_en);
  assign rd_pop         = o_rd_valid && i_rd_en;
  assign rd_pop_bin_nxt = rd_pop_bin + 1'b1;

  always_ff @(posedge i_rd_clk or negedge i_rd_rstn) begin
    if (!i_rd_rstn) begin
      rd_bin      <= '0;
      rd_pop_bin  <= '0;
      rd_pop_gray <= '0;
      o_rd_valid  <= 1'b0;
      o_rd_data   <= '0;
    end else begin
      if (rd_load) begin
        rd_bin     <= rd_bin + 1'b1;
        o_rd_data  <= mem[rd_bin[ADDR_WIDTH-1:0]];
        o_rd_valid <= 1'b1;
      end else if (rd_pop) begin
        o_rd_valid <= 1'b0;
      end
      if (rd_pop) begin
        rd_pop_bin  <= rd_pop_bin_nxt;
        rd_pop_gray <= PTR_W'(bin2gray(MAX_PTR_W'(rd_pop_bin_nxt)));
      end
    end
  end

  assign o_rd_level        = rd_ram_cnt + PTR_W'(o_rd_valid);
  assign o_rd_almost_empty = (o_rd_level <= PTR_W'(AEMPTY_THRESH));

  sakebi_gray_sync #(.WIDTH(PTR_W)) u_wr2rd_sync (
    .i_clk  (i_rd_clk),
    .i_rstn (i_rd_rstn),
    .i_gray (wr_gray),
    .o_bin  (wr_sync_bin)
  );

`ifdef SAKEBI_FIFO_ERR_FLAGS_EN
  always_ff @(posedge i_wr_clk or negedge i_wr_rstn) begin
    if (!i_wr_rstn)              o_wr_overflow <= 1'b0;
    else if (i_wr_en && wr_full) o_wr_overflow <= 1'b1;
  end

  always_ff @(posedge i_rd_clk or negedge i_rd_rstn) begin
    if (!i_rd_rstn)                  o_rd_underflow <= 1'b0;
    else if (i_rd_en && !o_rd_valid) o_rd_underflow <= 1'b1;
  end
`else
  // Push-while-full and pop-while-empty are dropped without any record.
`endif

endmodule

// File: tb/tb_sakebi_async_fifo_lvl.sv
// Directed bench for sakebi_async_fifo_lvl: vector table for the fill phase plus
// hand-written sequences for latency, streaming, underflow and reset corners.
`timescale 1ns/100ps
module tb_sakebi_async_fifo_lvl;

  logic       wr_clk = 1'b0, rd_clk = 1'b0;
  logic       i_wr_rstn, i_rd_rstn, i_wr_en, i_rd_en;
  logic [7:0] i_wr_data;
  logic       o_wr_ready, o_wr_almost_full, o_rd_valid, o_rd_almost_empty;
  logic [4:0] o_wr_level, o_rd_level;
  logic [7:0] o_rd_data;
`ifdef SAKEBI_FIFO_ERR_FLAGS_EN
  logic       o_wr_overflow, o_rd_underflow;
`endif

  realtime wr_half = 5.0;
  realtime rd_half = 13.5;
  always #(wr_half) wr_clk = ~wr_clk;
  always #(rd_half) rd_clk = ~rd_clk;

  sakebi_async_fifo_lvl dut (
    .i_wr_clk          (wr_clk),
    .i_wr_rstn         (i_wr_rstn),
    .i_wr_en           (i_wr_en),
    .i_wr_data         (i_wr_data),
    .o_wr_ready        (o_wr_ready),
    .o_wr_level        (o_wr_level),
    .o_wr_almost_full  (o_wr_almost_full),
    .i_rd_clk          (rd_clk),
    .i_rd_rstn         (i_rd_rstn),
    .i_rd_en           (i_rd_en),
    .o_rd_valid        (o_rd_valid),
    .o_rd_data         (o_rd_data),
    .o_rd_level        (o_rd_level),
    .o_rd_almost_empty (o_rd_almost_empty)
`ifdef SAKEBI_FIFO_ERR_FLAGS_EN
    ,
    .o_wr_overflow     (o_wr_overflow),
    .o_rd_underflow    (o_rd_underflow)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic       en;
    logic [7:0] d;
    logic [4:0] lvl;
    logic       rdy;
    logic       af;
  } wvec_t;
  wvec_t wv[21];

  logic [7:0] sb_q[$];
  int sent, rcvd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Both resets must move together; a lone reset is an illegal use of the block.
  always @(posedge wr_clk or posedge rd_clk) begin
    if (i_wr_rstn !== i_rd_rstn) begin
      n_chk++;
      n_err++;
      $display("FAIL reset_pair: wr_rstn=%b rd_rstn=%b", i_wr_rstn, i_rd_rstn);
    end
  end

  task automatic push1(input logic [7:0] d);
    @(negedge wr_clk);
    i_wr_en = 1'b1;
    i_wr_data = d;
    @(negedge wr_clk);
    i_wr_en = 1'b0;
  endtask

  task automatic rd_pop(output logic [7:0] d, output bit ok);
    int n = 0;
    ok = 1'b0;
    d = 8'h00;
    @(negedge rd_clk);
    while (!o_rd_valid && n < 40) begin
      @(negedge rd_clk);
      n++;
    end
    if (o_rd_valid) begin
      ok = 1'b1;
      d = o_rd_data;
      i_rd_en = 1'b1;
      @(negedge rd_clk);
      i_rd_en = 1'b0;
    end
  endtask

  task automatic pop_expect(input string nm, input logic [7:0] exp);
    logic [7:0] d;
    bit ok;
    rd_pop(d, ok);
    if (!ok) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: timeout waiting for o_rd_valid, expected data 0x%0h", nm, exp);
    end else begin
      chk(nm, 32'(d), 32'(exp));
    end
  endtask

  task automatic stream(input int nwords);
    sent = 0;
    rcvd = 0;
    sb_q.delete();
    fork
      begin
        int pc = 0;
        while (sent < nwords && pc < 20000) begin
          @(negedge wr_clk);
          pc++;
          if (o_wr_ready && ($urandom_range(3) != 0)) begin
            i_wr_data = 8'(sent * 7 + 3);
            i_wr_en = 1'b1;
            sb_q.push_back(i_wr_data);
            sent++;
          end else begin
            i_wr_en = 1'b0;
          end
        end
        @(negedge wr_clk);
        i_wr_en = 1'b0;
      end
      begin
        int cc = 0;
        logic [7:0] exp;
        while (rcvd < nwords && cc < 40000) begin
          @(negedge rd_clk);
          cc++;
          i_rd_en = ($urandom_range(3) != 0);
          if (o_rd_valid && i_rd_en) begin
            if (sb_q.size() == 0) begin
              n_chk++;
              n_err++;
              $display("FAIL stream_extra: got 0x%0h, expected no word", o_rd_data);
            end else begin
              exp = sb_q.pop_front();
              chk("stream_data", 32'(o_rd_data), 32'(exp));
            end
            rcvd++;
          end
        end
        @(negedge rd_clk);
        i_rd_en = 1'b0;
      end
    join
    chk("stream_sent", 32'(sent), 32'(nwords));
    chk("stream_rcvd", 32'(rcvd), 32'(nwords));
    chk("stream_left", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    bit seen;
    i_wr_rstn = 1'b0;
    i_rd_rstn = 1'b0;
    i_wr_en   = 1'b0;
    i_rd_en   = 1'b0;
    i_wr_data = 8'h00;

    for (int k = 0; k < 16; k++)
      wv[k] = '{1'b1, 8'(k), 5'(k + 1), (k + 1 < 16), (k + 1 >= 14)};
    for (int k = 16; k < 21; k++)
      wv[k] = '{1'b1, 8'hEE, 5'd16, 1'b0, 1'b1};

    // reset state
    #20;
    chk("rst_wr_ready", 32'(o_wr_ready), 32'd1);
    chk("rst_wr_level", 32'(o_wr_level), 32'd0);
    chk("rst_wr_af", 32'(o_wr_almost_full), 32'd0);
    chk("rst_rd_valid", 32'(o_rd_valid), 32'd0);
    chk("rst_rd_data", 32'(o_rd_data), 32'd0);
    chk("rst_rd_level", 32'(o_rd_level), 32'd0);
    chk("rst_rd_ae", 32'(o_rd_almost_empty), 32'd1);
    #33;
    i_wr_rstn = 1'b1;
    i_rd_rstn = 1'b1;

    // fill to full, then push attempts while full
    @(negedge wr_clk);
    for (int k = 0; k < 21; k++) begin
      i_wr_en = wv[k].en;
      i_wr_data = wv[k].d;
      @(negedge wr_clk);
      chk($sformatf("fill_level[%0d]", k), 32'(o_wr_level), 32'(wv[k].lvl));
      chk($sformatf("fill_ready[%0d]", k), 32'(o_wr_ready), 32'(wv[k].rdy));
      chk($sformatf("fill_af[%0d]", k), 32'(o_wr_almost_full), 32'(wv[k].af));
    end
    i_wr_en = 1'b0;
    repeat (6) @(negedge rd_clk);
    chk("full_rd_level", 32'(o_rd_level), 32'd16);
    chk("full_rd_valid", 32'(o_rd_valid), 32'd1);
    chk("full_rd_ae", 32'(o_rd_almost_empty), 32'd0);
`ifdef SAKEBI_FIFO_ERR_FLAGS_EN
    chk("overflow_set", 32'(o_wr_overflow), 32'd1);
`endif

    // first pop from full must release o_wr_ready within 3 write edges
    pop_expect("drain_data[0]", 8'h00);
    seen = 1'b0;
    for (int e = 0; e < 3 && !seen; e++) begin
      @(posedge wr_clk);
      #1;
      if (o_wr_ready) seen = 1'b1;
    end
    chk("full_release", 32'(seen), 32'd1);
    chk("release_level", 32'(o_wr_level), 32'd15);
    for (int k = 1; k < 16; k++) pop_expect($sformatf("drain_data[%0d]", k), 8'(k));
    repeat (4) @(negedge rd_clk);
    chk("drained_valid", 32'(o_rd_valid), 32'd0);
    chk("drained_rd_level", 32'(o_rd_level), 32'd0);
    chk("drained_ae", 32'(o_rd_almost_empty), 32'd1);
    chk("drained_wr_level", 32'(o_wr_level), 32'd0);

    // single push into empty, equal clocks: valid by the 4th read edge
    wr_half = 5.0;
    rd_half = 5.0;
    repeat (4) @(negedge wr_clk);
    @(negedge wr_clk);
    i_wr_en = 1'b1;
    i_wr_data = 8'hA5;
    @(posedge wr_clk);
    #1 i_wr_en = 1'b0;
    seen = 1'b0;
    for (int e = 0; e < 4 && !seen; e++) begin
      @(posedge rd_clk);
      #1;
      if (o_rd_valid) seen = 1'b1;
    end
    chk("latency_valid", 32'(seen), 32'd1);
    chk("single_data", 32'(o_rd_data), 32'hA5);
    chk("single_rd_level", 32'(o_rd_level), 32'd1);
    chk("single_ae", 32'(o_rd_almost_empty), 32'd1);
    pop_expect("single_pop", 8'hA5);
    chk("after_pop_valid", 32'(o_rd_valid), 32'd0);
    chk("after_pop_level", 32'(o_rd_level), 32'd0);
    chk("after_pop_ae", 32'(o_rd_almost_empty), 32'd1);

    // pop requests against an empty FIFO
    @(negedge rd_clk);
    i_rd_en = 1'b1;
    repeat (10) @(negedge rd_clk);
    chk("underrun_valid", 32'(o_rd_valid), 32'd0);
    chk("underrun_level", 32'(o_rd_level), 32'd0);
`ifdef SAKEBI_FIFO_ERR_FLAGS_EN
    chk("underflow_set", 32'(o_rd_underflow), 32'd1);
`endif
    i_rd_en = 1'b0;
    push1(8'h5A);
    pop_expect("post_underrun_data", 8'h5A);

    // streaming: write faster, then read faster
    wr_half = 5.0;
    rd_half = 15.0;
    stream(1000);
    wr_half = 15.0;
    rd_half = 5.0;
    stream(1000);

    // reset both domains with 9 words stored
    wr_half = 5.0;
    rd_half = 5.0;
    repeat (4) @(negedge wr_clk);
    for (int k = 0; k < 9; k++) push1(8'(8'h40 + k));
    repeat (8) @(negedge rd_clk);
    chk("pre_reset_wr_level", 32'(o_wr_level), 32'd9);
    chk("pre_reset_rd_level", 32'(o_rd_level), 32'd9);
    #2;
    i_wr_rstn = 1'b0;
    i_rd_rstn = 1'b0;
    #1;
    chk("mid_rst_wr_ready", 32'(o_wr_ready), 32'd1);
    chk("mid_rst_wr_level", 32'(o_wr_level), 32'd0);
    chk("mid_rst_wr_af", 32'(o_wr_almost_full), 32'd0);
    chk("mid_rst_rd_valid", 32'(o_rd_valid), 32'd0);
    chk("mid_rst_rd_data", 32'(o_rd_data), 32'd0);
    chk("mid_rst_rd_level", 32'(o_rd_level), 32'd0);
    chk("mid_rst_rd_ae", 32'(o_rd_almost_empty), 32'd1);
    repeat (3) @(negedge wr_clk);
    i_wr_rstn = 1'b1;
    i_rd_rstn = 1'b1;
    repeat (6) @(negedge rd_clk);
    chk("post_rst_wr_level", 32'(o_wr_level), 32'd0);
    chk("post_rst_rd_valid", 32'(o_rd_valid), 32'd0);
    chk("post_rst_rd_level", 32'(o_rd_level), 32'd0);
`ifdef SAKEBI_FIFO_ERR_FLAGS_EN
    chk("post_rst_overflow", 32'(o_wr_overflow), 32'd0);
    chk("post_rst_underflow", 32'(o_rd_underflow), 32'd0);
`endif
    push1(8'h3C);
    pop_expect("post_rst_data", 8'h3C);
    repeat (6) @(negedge rd_clk);
    chk("post_rst_no_stale", 32'(o_rd_valid), 32'd0);
    chk("post_rst_final_wr_level", 32'(o_wr_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sakebi_async_fifo_lvl.md
Name: sakebi_async_fifo_lvl

Overview:
Parametrised dual-clock FIFO, next generation of the team's async FIFO.
- Uses the full DEPTH capacity via (ADDR_WIDTH+1)-bit Gray pointers.
- Adds per-domain fill levels and programmable almost-full / almost-empty flags.
- Read side is first-word-fall-through with a valid/ready handshake.
- Sits on every clock-domain crossing between the network-side and sakebi core datapaths.

Parameters:
- DATA_WIDTH, 8, payload width in bits.
- DEPTH, 16, number of entries; power of two, at least 4.
- AFULL_THRESH, DEPTH-2, o_wr_almost_full asserts when write level >= this value.
- AEMPTY_THRESH, 2, o_rd_almost_empty asserts when read level <= this value.

Ports:
- i_wr_clk  in  1  write clock
- i_wr_rstn  in  1  write-domain reset
- i_wr_en  in  1  push request
- i_wr_data  in  DATA_WIDTH  push data
- o_wr_ready  out  1  not full
- o_wr_level  out  ADDR_WIDTH+1  entries used, write-domain view
- o_wr_almost_full  out  1  o_wr_level >= AFULL_THRESH
- i_rd_clk  in  1  read clock
- i_rd_rstn  in  1  read-domain reset, asynchronous, active-low
- i_rd_en  in  1  consumer ready / pop
- o_rd_valid  out  1  o_rd_data holds a valid word
- o_rd_data  out  DATA_WIDTH  head-of-FIFO data, registered
- o_rd_level  out  ADDR_WIDTH+1  entries available, including the output register
- o_rd_almost_empty  out  1  o_rd_level <= AEMPTY_THRESH

Interface: reset i_wr_rstn, asynchronous, active-low; clock i_wr_clk.

Behaviour:
- ADDR_WIDTH = $clog2(DEPTH).
- Pointer format: PTR_W = ADDR_WIDTH+1 bits, binary plus registered Gray copy. RAM is indexed by the low ADDR_WIDTH bits.
- Full: write Gray == synced read Gray with the top two bits inverted.
- Empty: read Gray == synced write Gray.
- All DEPTH entries are usable.
- Push:
  - A push occurs on an i_wr_clk edge when i_wr_en && o_wr_ready.
  - i_wr_en while full is ignored: no pointer move, no RAM write.
- Level arithmetic: o_wr_level = wr_bin - synced_rd_bin, modulo 2^PTR_W. It ranges 0..DEPTH and wraps correctly across pointer rollover.
- Synchronisers: each Gray pointer crosses through 2 flops in the destination domain, reset to 0 by that domain's reset.
- FWFT output stage:
  - The output register loads when the RAM is not empty and (!o_rd_valid || i_rd_en).
  - Handshake completes on an i_rd_clk edge with o_rd_valid && i_rd_en.
  - i_rd_en while !o_rd_valid has no effect.
- Read latency: a push into an empty FIFO raises o_rd_valid no later than the 4th i_rd_clk rising edge after the write edge. Path: 1 wr-side Gray register, 2 sync flops, 1 output load.
- Full release latency: a pop from a full FIFO raises o_wr_ready no later than the 3rd i_wr_clk edge after the pop edge.
- Flags are pessimistic: full/almost_full may stay high, and empty/almost_empty may stay asserted, for the sync latency. They never report optimistically.
- o_rd_level = (synced_wr_bin - rd_bin) + o_rd_valid. The output-register word is counted.
- Reset values:
  - Write side: o_wr_ready 1, o_wr_level 0, o_wr_almost_full 0.
  - Read side: o_rd_valid 0, o_rd_data 0, o_rd_level 0, o_rd_almost_empty 1.
- Reset mid-operation: only asserting both resets together is supported, and it drops all contents. Asserting one reset alone is illegal, and the verification engineer flags it with an assertion.
- RAM has no reset.

Optional Feature:
- Macro SAKEBI_FIFO_ERR_FLAGS_EN.
- When defined, adds ports o_wr_overflow (1, out) and o_rd_underflow (1, out). Both are sticky and cleared only by their domain reset.
  - o_wr_overflow sets on i_wr_en && !o_wr_ready.
  - o_rd_underflow sets on i_rd_en && !o_rd_valid.
- When undefined, the ports and logic are absent, and push-while-full and pop-while-empty are silently ignored.

Decomposition:
- Package sakebi_fifo_pkg: bin2gray / gray2bin functions parametrised on width, and a helper computing PTR_W from DEPTH.
- One sub-module, sakebi_gray_sync:
  - Parameter WIDTH.
  - Ports: i_clk, i_rstn, i_gray, o_bin.
  - 2-flop synchroniser plus Gray-to-binary conversion; instantiated once per direction.
- RAM stays inline.

Test Plan:
- Reset, then 16 pushes of 0x00..0x0F at 100 MHz wr / 37 MHz rd, no pops -> o_wr_ready falls after the 16th push, o_wr_level=16, o_wr_almost_full high from level 14. Pops then return 0x00..0x0F in order.
- Single push of 0xA5 into empty FIFO, equal clocks -> o_rd_valid high by the 4th rd edge, o_rd_data=0xA5, o_rd_level=1. After the pop: valid drops, o_rd_almost_empty=1.
- Continuous push/pop for 1000 words with wr 3x faster than rd, then rd 3x faster than wr -> pointers wrap at least 60 times, scoreboard shows no loss, duplication or reorder.
- Push attempts while full (i_wr_en held 5 cycles) -> level stays 16, data unchanged. With SAKEBI_FIFO_ERR_FLAGS_EN, o_wr_overflow=1 until reset.
- i_rd_en held while empty for 10 cycles -> no pointer movement, o_rd_valid=0. With the macro defined, o_rd_underflow=1.
- Both resets asserted with 9 entries stored -> all outputs return to reset values, o_wr_level=0. Next push/pop pair returns only the new data.
